// File: rtl/mprj_monitor_pkg.sv
// Shared types and default codes for the status-code monitor.
package mprj_monitor_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_START,
      RUN,
      PASS,
      FAIL,
      TIMEOUT
   } state_t;

   localparam logic [15:0] DEF_START_CODE = 16'hAB60;
   localparam logic [15:0] DEF_PASS_CODE  = 16'hAB61;

endpackage

// File: rtl/mprj_status_sync_filter.sv
// Two-flop synchroniser plus stability counter for the status bus.
module status_sync_filter #(
   parameter int WIDTH         = 16,
   parameter int STABLE_CYCLES = 2
) (
   input  logic             clock,
   input  logic             resetb,
   input  logic [WIDTH-1:0] checkbits,
   output logic [WIDTH-1:0] code_q,
   output logic             valid
);

   localparam int SW = (STABLE_CYCLES > 1) ?
                       $clog2(STABLE_CYCLES) : 1;
   localparam logic [SW-1:0] CNT_TOP = SW'(STABLE_CYCLES - 1);

   logic [WIDTH-1:0] meta_q;
   logic [SW-1:0]    stable_q;
   logic [SW-1:0]    stable_d;

   // meta_q differing from code_q means code_q changes on this edge
   always_comb begin
      stable_d = stable_q;
      if (meta_q != code_q) begin
         stable_d = '0;
      end else if (stable_q != CNT_TOP) begin
         stable_d = stable_q + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         meta_q   <= '0;
         code_q   <= '0;
         stable_q <= '0;
      end else begin
         meta_q   <= checkbits;
         code_q   <= meta_q;
         stable_q <= stable_d;
      end
   end

   assign valid = (stable_q == CNT_TOP);

endmodule

// File: rtl/mprj_status_monitor.sv
// Filtered status-code watcher: start, progress, pass/fail/timeout.
module mprj_status_monitor
   import mprj_monitor_pkg::*;
#(
   parameter int               WIDTH          = 16,
   parameter logic [WIDTH-1:0] START_CODE     = WIDTH'(DEF_START_CODE),
   parameter logic [WIDTH-1:0] PASS_CODE      = WIDTH'(DEF_PASS_CODE),
   parameter int               STABLE_CYCLES  = 2,
   parameter int               TIMEOUT_CYCLES = 70000,
   parameter bit               PROGRESS_EN    = 1'b1,
   parameter int               CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic             clock,
   input  logic             resetb,
   input  logic             enable,
   input  logic             clear,
   input  logic [WIDTH-1:0] checkbits,
   output logic             started,
   output logic             done,
   output logic             passed,
   output logic             failed,
   output logic             timed_out,
   output logic [WIDTH-1:0] fail_code,
   output logic [7:0]       stage_count,
   output logic [CNT_W-1:0] cycle_count
);

   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [WIDTH-1:0] code;
   logic             valid;

   status_sync_filter #(
      .WIDTH        (WIDTH),
      .STABLE_CYCLES(STABLE_CYCLES)
   ) u_filter (
      .clock    (clock),
      .resetb   (resetb),
      .checkbits(checkbits),
      .code_q   (code),
      .valid    (valid)
   );

   state_t           state_q, state_d;
   logic             started_q, started_d;
   logic             done_q, done_d;
   logic             passed_q, passed_d;
   logic             failed_q, failed_d;
   logic             timed_out_q, timed_out_d;
   logic [WIDTH-1:0] fail_code_q, fail_code_d;
   logic [7:0]       stage_q, stage_d;
   logic [7:0]       last_lo_q, last_lo_d;
   logic [CNT_W-1:0] cyc_q, cyc_d;

   logic             hi_match;
   logic             cand;
   logic             is_pass;
   logic             is_prog;
   logic             is_rep;
   logic             is_fail;
   logic             tmo;
   logic             kill;
   logic [CNT_W-1:0] cyc_inc;
   logic [7:0]       stage_inc;

   assign hi_match = code[WIDTH-1:8] == START_CODE[WIDTH-1:8];
   assign cand     = valid && (code != START_CODE);
   assign is_pass  = cand && (code == PASS_CODE);
   assign is_prog  = cand && !is_pass && PROGRESS_EN &&
                     hi_match && (code[7:0] > last_lo_q);
   // a held or repeated progress code must not count as a failure
   assign is_rep   = cand && hi_match && (code[7:0] == last_lo_q);
   assign is_fail  = cand && !is_pass && !is_prog && !is_rep;
   assign tmo      = (cyc_q == TMO_LAST);
   assign kill     = clear || (!enable &&
                     (state_q == WAIT_START || state_q == RUN));

   assign cyc_inc   = (cyc_q == CNT_MAX) ? cyc_q : cyc_q + 1'b1;
   assign stage_inc = (stage_q == 8'hFF) ? stage_q : stage_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      started_d   = started_q;
      fail_code_d = fail_code_q;
      stage_d     = stage_q;
      last_lo_d   = last_lo_q;
      cyc_d       = cyc_q;
      if (kill) begin
         state_d     = IDLE;
         started_d   = 1'b0;
         fail_code_d = '0;
         stage_d     = '0;
         last_lo_d   = '0;
         cyc_d       = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (enable) begin
                  state_d     = WAIT_START;
                  fail_code_d = '0;
                  stage_d     = '0;
                  last_lo_d   = '0;
                  cyc_d       = '0;
               end
            end
            WAIT_START: begin
               if (tmo) begin
                  state_d = TIMEOUT;
               end else begin
                  cyc_d = cyc_inc;
                  if (valid && code == START_CODE) begin
                     state_d   = RUN;
                     started_d = 1'b1;
                     last_lo_d = START_CODE[7:0];
                  end
               end
            end
            RUN: begin
               if (is_pass) begin
                  state_d = PASS;
               end else if (is_fail) begin
                  state_d     = FAIL;
                  fail_code_d = code;
               end else if (tmo) begin
                  state_d = TIMEOUT;
               end else begin
                  cyc_d = cyc_inc;
                  if (is_prog) begin
                     stage_d   = stage_inc;
                     last_lo_d = code[7:0];
                  end
               end
            end
            default: begin
            end
         endcase
      end
      done_d      = (state_d == PASS) || (state_d == FAIL) ||
                    (state_d == TIMEOUT);
      passed_d    = (state_d == PASS);
      failed_d    = (state_d == FAIL);
      timed_out_d = (state_d == TIMEOUT);
   end

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         state_q     <= IDLE;
         started_q   <= 1'b0;
         done_q      <= 1'b0;
         passed_q    <= 1'b0;
         failed_q    <= 1'b0;
         timed_out_q <= 1'b0;
         fail_code_q <= '0;
         stage_q     <= '0;
         last_lo_q   <= '0;
         cyc_q       <= '0;
      end else begin
         state_q     <= state_d;
         started_q   <= started_d;
         done_q      <= done_d;
         passed_q    <= passed_d;
         failed_q    <= failed_d;
         timed_out_q <= timed_out_d;
         fail_code_q <= fail_code_d;
         stage_q     <= stage_d;
         last_lo_q   <= last_lo_d;
         cyc_q       <= cyc_d;
      end
   end

   assign started     = started_q;
   assign done        = done_q;
   assign passed      = passed_q;
   assign failed      = failed_q;
   assign timed_out   = timed_out_q;
   assign fail_code   = fail_code_q;
   assign stage_count = stage_q;
   assign cycle_count = cyc_q;

endmodule

// File: tb/tb_mprj_status_monitor.sv
// Bench for mprj_status_monitor: vectors, corner sequences, random vs model.
module tb_mprj_status_monitor;

   localparam int STB = 2;
   localparam int TMO = 100;
   localparam int CW  = $clog2(TMO + 1);
   localparam logic [15:0] ST = 16'hAB60;
   localparam logic [15:0] PS = 16'hAB61;

   localparam int MS_IDLE = 0;
   localparam int MS_WAIT = 1;
   localparam int MS_RUN  = 2;
   localparam int MS_PASS = 3;
   localparam int MS_FAIL = 4;
   localparam int MS_TMO  = 5;

   logic          clock = 1'b0;
   logic          resetb = 1'b0;
   logic          enable = 1'b0;
   logic          clear = 1'b0;
   logic [15:0]   checkbits = '0;
   logic          started, done, passed, failed, timed_out;
   logic [15:0]   fail_code;
   logic [7:0]    stage_count;
   logic [CW-1:0] cycle_count;

   int checks = 0;
   int passes = 0;

   always #5 clock = ~clock;

   mprj_status_monitor #(
      .WIDTH         (16),
      .START_CODE    (ST),
      .PASS_CODE     (PS),
      .STABLE_CYCLES (STB),
      .TIMEOUT_CYCLES(TMO),
      .PROGRESS_EN   (1'b1)
   ) dut (
      .clock      (clock),
      .resetb     (resetb),
      .enable     (enable),
      .clear      (clear),
      .checkbits  (checkbits),
      .started    (started),
      .done       (done),
      .passed     (passed),
      .failed     (failed),
      .timed_out  (timed_out),
      .fail_code  (fail_code),
      .stage_count(stage_count),
      .cycle_count(cycle_count)
   );

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference model: the filter is a window over raw input samples
   int          m_st;
   bit          m_started;
   logic [15:0] m_fc;
   int          m_stage;
   int          m_cyc;
   int          m_last;
   logic [15:0] hist[$];

   task automatic model_clear();
      m_st = MS_IDLE;
      m_started = 0;
      m_fc = '0;
      m_stage = 0;
      m_cyc = 0;
      m_last = 0;
   endtask

   task automatic model_reset();
      model_clear();
      hist.delete();
      for (int i = 0; i <= STB; i++) hist.push_back(16'h0);
   endtask

   task automatic model_step(input bit en, input bit clr,
                             input logic [15:0] cb);
      bit vld;
      bit term;
      bit prog;
      logic [15:0] c;
      c = hist[1];
      vld = 1;
      for (int i = 2; i <= STB; i++) if (hist[i] != c) vld = 0;
      hist.push_front(cb);
      void'(hist.pop_back());
      if (clr || (!en && (m_st == MS_WAIT || m_st == MS_RUN))) begin
         model_clear();
      end else if (m_st == MS_IDLE) begin
         if (en) begin
            model_clear();
            m_st = MS_WAIT;
         end
      end else if (m_st == MS_WAIT) begin
         if (m_cyc == TMO - 1) m_st = MS_TMO;
         else begin
            m_cyc++;
            if (vld && c == ST) begin
               m_st = MS_RUN;
               m_started = 1;
               m_last = int'(ST[7:0]);
            end
         end
      end else if (m_st == MS_RUN) begin
         term = 0;
         prog = 0;
         if (vld && c != ST) begin
            if (c == PS) begin
               m_st = MS_PASS;
               term = 1;
            end else if (c[15:8] == ST[15:8] && int'(c[7:0]) > m_last)
               prog = 1;
            else if (!(c[15:8] == ST[15:8] && int'(c[7:0]) == m_last)) begin
               m_st = MS_FAIL;
               m_fc = c;
               term = 1;
            end
         end
         if (!term) begin
            if (m_cyc == TMO - 1) m_st = MS_TMO;
            else begin
               m_cyc++;
               if (prog) begin
                  if (m_stage < 255) m_stage++;
                  m_last = int'(c[7:0]);
               end
            end
         end
      end
   endtask

   function automatic logic [35:0] dut_vec();
      return {started, done, passed, failed, timed_out,
              fail_code, stage_count, cycle_count};
   endfunction

   function automatic logic [35:0] mdl_vec();
      logic dn;
      dn = (m_st == MS_PASS) || (m_st == MS_FAIL) || (m_st == MS_TMO);
      return {m_started, dn, m_st == MS_PASS, m_st == MS_FAIL,
              m_st == MS_TMO, m_fc, 8'(m_stage), CW'(m_cyc)};
   endfunction

   // Called at a negedge; returns at the next negedge.
   task automatic step(input bit en, input bit clr,
                       input logic [15:0] cb);
      enable = en;
      clear = clr;
      checkbits = cb;
      @(posedge clock);
      model_step(en, clr, cb);
      #1;
      chk("model", 64'(dut_vec()), 64'(mdl_vec()));
      @(negedge clock);
   endtask

   task automatic do_clear(input logic [15:0] cb);
      step(0, 1, cb);
      repeat (3) step(0, 0, cb);
   endtask

   typedef struct {
      int n;
      logic [4:0][15:0] c;
      logic p, f, t;
      logic [7:0] stg;
      logic [15:0] fc;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input int n, input logic [15:0] c0, c1, c2, c3, c4,
                      input logic p, f, t, input logic [7:0] stg,
                      input logic [15:0] fc);
      vec_t v;
      v.n = n;
      v.c[0] = c0;
      v.c[1] = c1;
      v.c[2] = c2;
      v.c[3] = c3;
      v.c[4] = c4;
      v.p = p;
      v.f = f;
      v.t = t;
      v.stg = stg;
      v.fc = fc;
      vecs.push_back(v);
   endtask

   initial begin
      logic [15:0] cd;
      int hold;
      int r;
      bit en;
      bit clr;

      add(2, ST, PS, 0, 0, 0, 1, 0, 0, 0, 16'h0);
      add(2, ST, 16'h1234, 0, 0, 0, 0, 1, 0, 0, 16'h1234);
      add(5, ST, 16'hAB62, 16'hAB62, 16'hAB65, PS, 1, 0, 0, 2, 16'h0);
      add(3, ST, 16'hAB65, 16'hAB63, 0, 0, 0, 1, 0, 1, 16'hAB63);
      add(3, ST, 16'hAB62, PS, 0, 0, 1, 0, 0, 1, 16'h0);
      add(2, ST, 16'hCD62, 0, 0, 0, 0, 1, 0, 0, 16'hCD62);
      add(3, ST, 16'hAB5F, PS, 0, 0, 0, 1, 0, 0, 16'hAB5F);
      add(3, 16'h1111, ST, PS, 0, 0, 1, 0, 0, 0, 16'h0);
      add(4, ST, 16'hAB62, ST, PS, 0, 1, 0, 0, 1, 16'h0);

      model_reset();
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("reset_state", 64'(dut_vec()), 64'h0);
      resetb = 1'b1;

      foreach (vecs[v]) begin
         do_clear(16'h0);
         step(1, 0, 16'h0);
         for (int i = 0; i < vecs[v].n; i++)
            repeat (4) step(1, 0, vecs[v].c[i]);
         repeat (4) step(1, 0, vecs[v].c[vecs[v].n-1]);
         chk($sformatf("vec%0d_flags", v),
             64'({started, done, passed, failed, timed_out}),
             64'({1'b1, 1'b1, vecs[v].p, vecs[v].f, vecs[v].t}));
         chk($sformatf("vec%0d_stage", v), 64'(stage_count),
             64'(vecs[v].stg));
         chk($sformatf("vec%0d_fcode", v), 64'(fail_code),
             64'(vecs[v].fc));
      end

      // transition latency: 2+STB edges after an input change
      do_clear(16'h0);
      repeat (2) step(1, 0, 16'h0);
      for (int i = 1; i <= 4; i++) begin
         step(1, 0, ST);
         chk($sformatf("start_lat%0d", i), 64'(started), 64'(i == 4));
      end
      for (int i = 1; i <= 4; i++) begin
         step(1, 0, PS);
         chk($sformatf("pass_lat%0d", i), 64'(passed), 64'(i == 4));
      end
      chk("pass_fcode", 64'(fail_code), 64'h0);

      // single-cycle glitch is filtered
      do_clear(16'h0);
      repeat (5) step(1, 0, ST);
      step(1, 0, 16'hFFFF);
      repeat (5) step(1, 0, ST);
      chk("glitch_nofail", 64'({started, failed, done}), 64'({3'b100}));
      repeat (3) step(1, 0, PS);
      repeat (3) step(1, 0, ST);
      chk("glitch_pass3", 64'(passed), 64'h1);

      // timeout
      do_clear(ST);
      step(1, 0, ST);
      repeat (99) step(1, 0, ST);
      chk("tmo_before", 64'({timed_out, cycle_count}), 64'({1'b0, 7'd99}));
      step(1, 0, ST);
      chk("tmo_hit", 64'({done, timed_out, passed, cycle_count}),
          64'({3'b110, 7'd99}));
      repeat (3) step(1, 0, PS);
      chk("tmo_sticky", 64'({timed_out, passed}), 64'({2'b10}));

      // pass validating on the timeout cycle wins
      do_clear(ST);
      step(1, 0, ST);
      repeat (96) step(1, 0, ST);
      repeat (3) step(1, 0, PS);
      chk("race_before", 64'({passed, timed_out}), 64'h0);
      step(1, 0, PS);
      chk("race_pass", 64'({passed, timed_out, cycle_count}),
          64'({2'b10, 7'd99}));

      // enable dropped in RUN
      do_clear(16'h0);
      repeat (6) step(1, 0, ST);
      chk("abort_run", 64'(started), 64'h1);
      step(0, 0, ST);
      chk("abort_idle", 64'(dut_vec()), 64'h0);

      // clear in PASS
      repeat (6) step(1, 0, ST);
      repeat (6) step(1, 0, PS);
      chk("clr_pass", 64'(passed), 64'h1);
      step(1, 1, PS);
      chk("clr_idle", 64'(dut_vec()), 64'h0);

      // async reset mid-RUN
      do_clear(16'h0);
      repeat (6) step(1, 0, ST);
      repeat (4) step(1, 0, 16'hAB62);
      chk("rst_pre", 64'(stage_count), 64'h1);
      #2 resetb = 1'b0;
      #1 chk("rst_async", 64'(dut_vec()), 64'h0);
      model_reset();
      @(posedge clock);
      @(negedge clock);
      resetb = 1'b1;

      // randomized runs against the model
      for (int s = 0; s < 40; s++) begin
         if ($urandom_range(0, 3) != 0) do_clear(16'h0);
         repeat (4) step(1, 0, ST);
         for (int j = 0; j < 8; j++) begin
            r = $urandom_range(0, 9);
            hold = $urandom_range(1, 5);
            if (r <= 3) cd = {8'hAB, 8'($urandom_range(8'h58, 8'h70))};
            else if (r == 4) cd = PS;
            else if (r == 5) cd = 16'($urandom);
            else if (r == 6) cd = ST;
            else if (r == 7) begin
               cd = 16'hFFFF;
               hold = 1;
            end else begin
               cd = ST;
               hold = 30;
            end
            en = ($urandom_range(0, 40) != 0);
            clr = ($urandom_range(0, 60) == 0);
            for (int k = 0; k < hold; k++)
               step(en || k > 0, clr && k == 0, cd);
         end
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/mprj_status_monitor.md
Name: mprj_status_monitor

Overview:
- Synthesizable successor to the testbench checkbits watcher, usable in RTL/GL benches and as an on-chip self-check block on the user GPIO side.
- Synchronises and glitch-filters a status-code bus, then runs a start → (progress)* → pass/fail/timeout sequence.
- Generalised in code width, start/pass codes, filter depth and timeout.
- Adds optional monotonic progress codes and latches the failing code and cycle count.

Parameters:
- WIDTH, 16, status bus width (≥ 9).
- START_CODE, 16'hAB60, code that arms the run.
- PASS_CODE, 16'hAB61, code that ends the run successfully.
- STABLE_CYCLES, 2, consecutive cycles a synchronised code must hold to count as valid (≥ 1).
- TIMEOUT_CYCLES, 70000, cycles allowed from enable to a terminal code.
- PROGRESS_EN, 1, accept increasing progress codes while running.
- CNT_W, $clog2(TIMEOUT_CYCLES+1), counter width (derived).

Ports:
- clock  in  1  system clock
- resetb  in  1  asynchronous active-low reset
- enable  in  1  start monitoring; low aborts a non-terminal run
- clear  in  1  synchronous return to IDLE from any state
- checkbits  in  WIDTH  asynchronous status code (e.g. mprj_io[31:16])
- started  out  1  run armed (RUN or later, until IDLE)
- done  out  1  any terminal state reached
- passed  out  1  PASS state
- failed  out  1  FAIL state
- timed_out  out  1  TIMEOUT state
- fail_code  out  WIDTH  filtered code that caused FAIL
- stage_count  out  8  progress codes accepted
- cycle_count  out  CNT_W  cycles since enable, frozen at terminal

Behaviour:
- Reset (resetb low, async): state IDLE; all outputs 0; synchroniser and filter registers 0.
- Input path: 2-flop synchroniser gives code_q.
  - stable_cnt clears when code_q changes; otherwise increments, saturating at STABLE_CYCLES-1.
  - valid = (stable_cnt == STABLE_CYCLES-1).
  - A code held on checkbits before edge k+1 changes state at edge k+2+STABLE_CYCLES.
  - Pulses shorter than STABLE_CYCLES synchronised cycles are ignored.
- IDLE: on enable → WAIT_START; cycle_count, stage_count and last_lo clear.
- WAIT_START: valid & code_q==START_CODE → RUN, started=1, last_lo = START_CODE[7:0]. Other valid codes are ignored.
- RUN: a valid code equal to START_CODE is ignored. For any other valid code, checks apply in priority order:
  1. code == PASS_CODE → PASS.
  2. PROGRESS_EN, code[WIDTH-1:8] == START_CODE[WIDTH-1:8] and code[7:0] > last_lo → stay in RUN; stage_count++ (saturating at 255); last_lo = code[7:0]. A repeated progress code must not re-increment: it fails the > test but equals last_lo, so it is ignored.
  3. Otherwise → FAIL; fail_code = code.
- Timeout: cycle_count increments every cycle in WAIT_START and RUN, saturating. When cycle_count reaches TIMEOUT_CYCLES-1 with no terminal code that cycle → TIMEOUT.
- Simultaneous events:
  - A terminal code validated in the same cycle as timeout wins.
  - clear beats everything.
  - enable low beats code/timeout in non-terminal states (→ IDLE, outputs cleared).
- Terminal states (PASS/FAIL/TIMEOUT): sticky; ignore enable and checkbits; exit only via clear or reset.
  - done=1 and exactly one of passed/failed/timed_out is set.
  - cycle_count, stage_count and fail_code hold.
- Status flags are registered: no combinational path from checkbits.

Decomposition:
- Package mprj_monitor_pkg:
  - state enum IDLE/WAIT_START/RUN/PASS/FAIL/TIMEOUT.
  - Default code constants 16'hAB60, 16'hAB61.
- Sub-module status_sync_filter (WIDTH, STABLE_CYCLES): synchroniser plus stability counter; outputs code_q and valid.
- The FSM and counters stay in the top module.

Test Plan:
- Nominal pass: after enable, drive 16'hAB60 then 16'hAB61 → started=1, then passed=1, done=1, fail_code=0. Each transition lands 2+STABLE_CYCLES edges after the input change.
- Fail: drive 16'hAB60 then 16'h1234 → failed=1, fail_code=16'h1234, passed=0.
- Progress: drive AB60, AB62, AB62, AB65, AB61 → stage_count=2, passed=1. Separately, AB60, AB65, AB63 → failed=1 with fail_code=16'hAB63.
- Glitch filter (STABLE_CYCLES=2): hold AB60, then a single-cycle 16'hFFFF pulse → no FAIL. AB61 held for 3 cycles → passed=1.
- Timeout (TIMEOUT_CYCLES=100): enable with AB60 only → timed_out=1 when cycle_count=99. A second run with AB61 validating on exactly that cycle → passed=1, timed_out=0.
- Abort/reset:
  - enable dropped in RUN → IDLE with all flags 0.
  - clear in PASS → IDLE.
  - resetb asserted mid-RUN → all outputs 0 immediately, without waiting for a clock edge.
